// File: rtl/key_debounce.sv
// Four-channel push-button conditioner: 2-FF synchroniser, per-channel debounce FSM,
// one-cycle press pulses and optional hold-to-repeat on masked channels.
module key_debounce #(
  parameter int          MCNT_DB     = 1_000_000,
  parameter int          MCNT_LONG   = 50_000_000,
  parameter int          MCNT_REP    = 10_000_000,
  parameter logic [3:0]  REPEAT_MASK = 4'b0011
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [3:0]  Key,
  output logic [3:0]  Key_flag,
  output logic [3:0]  Key_state,
  output logic [11:0] o_dbg_state
);

  localparam int HOLD_MAX = (MCNT_LONG > MCNT_REP) ? MCNT_LONG : MCNT_REP;
  localparam int DB_W     = (MCNT_DB  > 1) ? $clog2(MCNT_DB)  : 1;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(MCNT_DB - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(MCNT_LONG - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(MCNT_REP - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PRESS_FILT = 3'd1,
    S_HELD       = 3'd2,
    S_REPEAT     = 3'd3,
    S_REL_FILT   = 3'd4
  } state_t;

  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_sync_key;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_sync1 <= 4'b1111;
      r_sync2 <= 4'b1111;
    end else begin
      r_sync1 <= Key;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sync_key = r_sync2;

  for (genvar i = 0; i < 4; i++) begin : g_chan
    state_t            r_state;
    logic [DB_W-1:0]   r_db_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_from_rep;
    logic              r_flag;
    logic              r_level;
    logic              w_sync;

    assign w_sync = w_sync_key[i];

    always_ff @(posedge Clk) begin
      if (!Reset_n) begin
        r_state    <= S_IDLE;
        r_db_cnt   <= '0;
        r_hold_cnt <= '0;
        r_from_rep <= 1'b0;
        r_flag     <= 1'b0;
        r_level    <= 1'b1;
      end else begin
        r_flag <= 1'b0;
        case (r_state)
          S_IDLE: begin
            if (!w_sync) begin
              r_state  <= S_PRESS_FILT;
              r_db_cnt <= DB_ONE;
            end
          end
          S_PRESS_FILT: begin
            if (w_sync) begin
              r_state  <= S_IDLE;
              r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
              r_state    <= S_HELD;
              r_flag     <= 1'b1;
              r_level    <= 1'b0;
              r_db_cnt   <= '0;
              r_hold_cnt <= '0;
            end else begin
              r_db_cnt <= r_db_cnt + DB_ONE;
            end
          end
          S_HELD: begin
            // A release sample wins over a coinciding repeat threshold.
            if (w_sync) begin
              r_state    <= S_REL_FILT;
              r_db_cnt   <= DB_ONE;
              r_from_rep <= 1'b0;
            end else if (REPEAT_MASK[i] && (r_hold_cnt == LONG_LAST)) begin
              r_state    <= S_REPEAT;
              r_flag     <= 1'b1;
              r_hold_cnt <= '0;
            end else begin
              r_hold_cnt <= r_hold_cnt + HOLD_ONE;
            end
          end
          S_REPEAT: begin
            if (w_sync) begin
              r_state    <= S_REL_FILT;
              r_db_cnt   <= DB_ONE;
              r_from_rep <= 1'b1;
            end else if (r_hold_cnt == REP_LAST) begin
              r_flag     <= 1'b1;
              r_hold_cnt <= '0;
            end else begin
              r_hold_cnt <= r_hold_cnt + HOLD_ONE;
            end
          end
          S_REL_FILT: begin
            // Hold count is frozen so a release glitch resumes where it left off.
            if (!w_sync) begin
              r_state  <= r_from_rep ? S_REPEAT : S_HELD;
              r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
              r_state    <= S_IDLE;
              r_level    <= 1'b1;
              r_db_cnt   <= '0;
              r_hold_cnt <= '0;
            end else begin
              r_db_cnt <= r_db_cnt + DB_ONE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end

    assign Key_flag[i]            = r_flag;
    assign Key_state[i]           = r_level;
    assign o_dbg_state[3*i +: 3]  = r_state;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: expected flag events (edge number, flag vector)
// are queued when a key is driven and popped by a monitor whenever Key_flag is non-zero.
module tb_key_debounce;

  localparam int DB   = 5;
  localparam int LONG = 20;
  localparam int REP  = 8;
  // Edges from the drive point (just after edge d) to the registered flag/level change.
  localparam int LAT  = DB + 2;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [3:0]  Key;
  logic [3:0]  Key_flag;
  logic [3:0]  Key_state;
  logic [11:0] dbg_state;

  int unsigned edge_n = 0;
  logic [35:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  key_debounce #(
    .MCNT_DB     (DB),
    .MCNT_LONG   (LONG),
    .MCNT_REP    (REP),
    .REPEAT_MASK (4'b0011)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Key         (Key),
    .Key_flag    (Key_flag),
    .Key_state   (Key_state),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset block
  always #5 Clk = ~Clk;
  always @(posedge Clk) edge_n <= edge_n + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic wait_to(input int unsigned target);
    while (edge_n < target) tick(1);
  endtask

  task automatic push_flag(input int unsigned at_edge, input logic [3:0] vec);
    exp_q.push_back({at_edge, vec});
  endtask

  // Scoreboard monitor: every non-zero flag must match the next queued event.
  always @(negedge Clk) begin
    if (Key_flag !== 4'b0000) begin
      if (exp_q.size() == 0)
        check("unexpected_flag", {28'd0, edge_n, Key_flag}, 64'd0);
      else
        check("flag_event", {28'd0, edge_n, Key_flag}, {28'd0, exp_q.pop_front()});
    end
  end

  initial begin
    int unsigned d;
    int unsigned r;
    int unsigned q;

    Reset_n = 1'b0;
    Key     = 4'b0000;
    tick(1);
    for (int k = 0; k < 4; k++) begin
      check("rst_flag", {60'd0, Key_flag}, 64'd0);
      check("rst_state", {60'd0, Key_state}, 64'hF);
      tick(1);
    end
    Key = 4'b1111;
    tick(1);
    Reset_n = 1'b1;
    tick(5);

    // Clean press on a non-repeating channel
    d = edge_n;
    Key[3] = 1'b0;
    push_flag(d + LAT, 4'b1000);
    wait_to(d + LAT - 1);
    check("k3_state_before", {63'd0, Key_state[3]}, 64'd1);
    tick(1);
    check("k3_state_pressed", {63'd0, Key_state[3]}, 64'd0);
    wait_to(d + 40);
    r = edge_n;
    Key[3] = 1'b1;
    wait_to(r + LAT - 1);
    check("k3_state_rel_pend", {63'd0, Key_state[3]}, 64'd0);
    tick(1);
    check("k3_state_released", {63'd0, Key_state[3]}, 64'd1);
    tick(3);
    check("k3_queue_empty", exp_q.size(), 64'd0);

    // Bouncing press: short low runs are rejected
    for (int b = 0; b < 4; b++) begin
      Key[2] = 1'b0;
      tick(3);
      Key[2] = 1'b1;
      tick(1);
    end
    check("k2_no_early_flag_state", {63'd0, Key_state[2]}, 64'd1);
    d = edge_n;
    Key[2] = 1'b0;
    push_flag(d + LAT, 4'b0100);
    wait_to(d + 10);
    check("k2_state_pressed", {63'd0, Key_state[2]}, 64'd0);
    Key[2] = 1'b1;
    tick(LAT + 1);
    check("k2_state_released", {60'd0, Key_state}, 64'hF);
    check("k2_queue_empty", exp_q.size(), 64'd0);

    // Long hold with auto-repeat
    d = edge_n;
    Key[1] = 1'b0;
    push_flag(d + LAT, 4'b0010);
    push_flag(d + LAT + LONG, 4'b0010);
    for (int k = 1; k <= 4; k++) push_flag(d + LAT + LONG + REP * k, 4'b0010);
    wait_to(d + 60);
    Key[1] = 1'b1;
    tick(LAT + REP + 2);
    check("k1_queue_empty", exp_q.size(), 64'd0);
    check("k1_state_released", {60'd0, Key_state}, 64'hF);

    // Release glitch during HELD
    d = edge_n;
    Key[0] = 1'b0;
    push_flag(d + LAT, 4'b0001);
    wait_to(d + 10);
    Key[0] = 1'b1;
    tick(2);
    Key[0] = 1'b0;
    check("k0_glitch_state_a", {63'd0, Key_state[0]}, 64'd0);
    tick(2);
    r = edge_n;
    Key[0] = 1'b1;
    wait_to(r + 2);
    check("k0_glitch_state_b", {63'd0, Key_state[0]}, 64'd0);
    wait_to(r + LAT - 1);
    check("k0_state_rel_pend", {63'd0, Key_state[0]}, 64'd0);
    tick(1);
    check("k0_state_released", {63'd0, Key_state[0]}, 64'd1);
    tick(3);
    check("k0_queue_empty", exp_q.size(), 64'd0);

    // Simultaneous press, then reset while held
    d = edge_n;
    Key[1:0] = 2'b00;
    push_flag(d + LAT, 4'b0011);
    wait_to(d + 10);
    Reset_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check("midrst_flag", {60'd0, Key_flag}, 64'd0);
      check("midrst_state", {60'd0, Key_state}, 64'hF);
    end
    q = edge_n;
    Reset_n = 1'b1;
    push_flag(q + LAT, 4'b0011);
    wait_to(q + LAT - 1);
    check("postrst_state_pend", {60'd0, Key_state}, 64'hF);
    tick(1);
    check("postrst_state_pressed", {60'd0, Key_state}, 64'hC);
    wait_to(q + 15);
    Key = 4'b1111;
    tick(LAT + 2);
    check("final_state", {60'd0, Key_state}, 64'hF);
    check("final_queue_empty", exp_q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
